// File: rtl/w_stage_writeback_pkg.sv
// Shared encodings for the writeback stage: load-extend, destination and write-data selects.
package w_stage_writeback_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam logic [4:0]  REG_RA     = 5'd31;

    localparam logic [2:0] READSEL_WORD = 3'd0;
    localparam logic [2:0] READSEL_LBU  = 3'd1;
    localparam logic [2:0] READSEL_LB   = 3'd2;
    localparam logic [2:0] READSEL_LHU  = 3'd3;
    localparam logic [2:0] READSEL_LH   = 3'd4;

    localparam logic [2:0] A3SEL_RT = 3'd0;
    localparam logic [2:0] A3SEL_RD = 3'd1;
    localparam logic [2:0] A3SEL_RA = 3'd2;

    localparam logic [2:0] WDSEL_ALU  = 3'd0;
    localparam logic [2:0] WDSEL_LOAD = 3'd1;
    localparam logic [2:0] WDSEL_PC8  = 3'd2;
    localparam logic [2:0] WDSEL_HI   = 3'd3;
    localparam logic [2:0] WDSEL_LO   = 3'd4;
    localparam logic [2:0] WDSEL_CP0  = 3'd5;
    localparam logic [2:0] WDSEL_EXT  = 3'd6;

endpackage

// File: rtl/w_stage_writeback_if.sv
// W-stage bundle: pipeline-register inputs, D-stage read ports and the published WB write triple.
interface w_stage_writeback_if
    import w_stage_writeback_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
);
    logic [31:0]   w_instr;
    logic [DW-1:0] w_pc8;
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_dm_word;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;
    logic [DW-1:0] w_cp0;
    logic [2:0]    w_readsel;
    logic [2:0]    w_a3sel;
    logic [2:0]    w_wdsel;
    logic          w_grf_en;
    logic          w_exc;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          wb_we;
    logic [4:0]    wb_a3;
    logic [DW-1:0] wb_wd;

    modport master (
        output w_instr, w_pc8, w_alu, w_dm_word, w_ext, w_hi, w_lo, w_cp0,
        output w_readsel, w_a3sel, w_wdsel, w_grf_en, w_exc, ra1, ra2,
        input  rd1, rd2, wb_we, wb_a3, wb_wd
    );

    modport slave (
        input  w_instr, w_pc8, w_alu, w_dm_word, w_ext, w_hi, w_lo, w_cp0,
        input  w_readsel, w_a3sel, w_wdsel, w_grf_en, w_exc, ra1, ra2,
        output rd1, rd2, wb_we, wb_a3, wb_wd
    );

endinterface

// File: rtl/w_stage_writeback_grf_2r1w.sv
// General register file: two combinational read ports, one write port, synchronous clear.
module grf_2r1w #(
    parameter int unsigned DW     = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else if (we && (wa != '0)) begin
            mem_q[wa] <= wd;
        end
    end

    // Entry 0 is never written, but reads of r0 are forced to zero regardless.
    always_comb begin
        rd1 = mem_q[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (BYPASS && we && (ra1 == wa)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = mem_q[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (BYPASS && we && (ra2 == wa)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/w_stage_writeback.sv
// Writeback stage: load extension, A3/WD selection, GRF ownership and WB forwarding triple.
// Optional W_TRACE_EN adds registered trace ports and a simulation write log.
module w_stage_writeback
    import w_stage_writeback_pkg::*;
#(
    parameter int unsigned DW     = DW_DEFAULT,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
`ifdef W_TRACE_EN
    output logic          trace_valid,
    output logic [DW-1:0] trace_pc,
    output logic [4:0]    trace_reg,
    output logic [DW-1:0] trace_data,
`endif
    w_stage_writeback_if.slave wif
);

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;
    logic [4:0]    a3;
    logic          a3_legal;
    logic [DW-1:0] wd;
    logic          wd_legal;
    logic          we;

    // Little-endian lanes; alignment was already trapped upstream.
    always_comb begin
        case (wif.w_alu[1:0])
            2'd0:    ld_byte = wif.w_dm_word[7:0];
            2'd1:    ld_byte = wif.w_dm_word[15:8];
            2'd2:    ld_byte = wif.w_dm_word[23:16];
            default: ld_byte = wif.w_dm_word[31:24];
        endcase
        ld_half = wif.w_alu[1] ? wif.w_dm_word[31:16] : wif.w_dm_word[15:0];
    end

    always_comb begin
        case (wif.w_readsel)
            READSEL_WORD: ld_data = wif.w_dm_word;
            READSEL_LBU:  ld_data = {{(DW-8){1'b0}}, ld_byte};
            READSEL_LB:   ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
            READSEL_LHU:  ld_data = {{(DW-16){1'b0}}, ld_half};
            READSEL_LH:   ld_data = {{(DW-16){ld_half[15]}}, ld_half};
            default:      ld_data = '0;
        endcase
    end

    always_comb begin
        a3_legal = 1'b1;
        case (wif.w_a3sel)
            A3SEL_RT: a3 = wif.w_instr[20:16];
            A3SEL_RD: a3 = wif.w_instr[15:11];
            A3SEL_RA: a3 = REG_RA;
            default: begin
                a3       = '0;
                a3_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        wd_legal = 1'b1;
        case (wif.w_wdsel)
            WDSEL_ALU:  wd = wif.w_alu;
            WDSEL_LOAD: wd = ld_data;
            WDSEL_PC8:  wd = wif.w_pc8;
            WDSEL_HI:   wd = wif.w_hi;
            WDSEL_LO:   wd = wif.w_lo;
            WDSEL_CP0:  wd = wif.w_cp0;
            WDSEL_EXT:  wd = wif.w_ext;
            default: begin
                wd       = '0;
                wd_legal = 1'b0;
            end
        endcase
    end

    // Reset in flight discards the W instruction, so it gates the write here too.
    assign we = wif.w_grf_en & ~wif.w_exc & ~reset & a3_legal & wd_legal & (a3 != '0);

    assign wif.wb_we = we;
    assign wif.wb_a3 = we ? a3 : '0;
    assign wif.wb_wd = we ? wd : '0;

    grf_2r1w #(
        .DW     (DW),
        .NREG   (NREG),
        .AW     (5),
        .BYPASS (BYPASS)
    ) u_grf (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .wa    (a3),
        .wd    (wd),
        .ra1   (wif.ra1),
        .ra2   (wif.ra2),
        .rd1   (wif.rd1),
        .rd2   (wif.rd2)
    );

    logic unused_w_bits;
    assign unused_w_bits = ^{wif.w_instr[31:21], wif.w_instr[10:0], wif.w_alu[DW-1:2],
                             wif.w_pc8};

`ifdef W_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_reg   <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= we;
            if (we) begin
                trace_pc   <= wif.w_pc8 - DW'(8);
                trace_reg  <= a3;
                trace_data <= wd;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (we) begin
            $display("@%h: $%d <= %h", wif.w_pc8 - DW'(8), a3, wd);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_w_stage_writeback.sv
// Randomised scoreboard bench for w_stage_writeback against a spec-level reference model.
module tb_w_stage_writeback;

    localparam bit TB_BYPASS = 1'b1;

    typedef struct {
        logic        reset;
        logic [31:0] instr, pc8, alu, dm, ext, hi, lo, cp0;
        logic [2:0]  readsel, a3sel, wdsel;
        logic        grf_en, exc;
        logic [4:0]  ra1, ra2;
    } stim_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd, rd1, rd2;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    w_stage_writeback_if #(.DW(32)) wif ();

`ifdef W_TRACE_EN
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
`endif

    w_stage_writeback #(
        .DW     (32),
        .NREG   (32),
        .BYPASS (TB_BYPASS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef W_TRACE_EN
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_reg   (trace_reg),
        .trace_data  (trace_data),
`endif
        .wif         (wif)
    );

    int    checks   = 0;
    int    failures = 0;
    exp_t  sb_q[$];
    logic [31:0] mdl [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] load_ext(input logic [31:0] dm, input logic [31:0] alu,
                                             input logic [2:0] sel);
        logic [31:0] b;
        logic [31:0] h;
        b = (dm >> (8 * alu[1:0])) & 32'hFF;
        h = (dm >> (16 * alu[1])) & 32'hFFFF;
        case (sel)
            3'd0:    return dm;
            3'd1:    return b;
            3'd2:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd3:    return h;
            3'd4:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.reset   = 1'b0;
        s.instr   = $urandom;
        s.pc8     = $urandom;
        s.alu     = $urandom;
        s.dm      = $urandom;
        s.ext     = $urandom;
        s.hi      = $urandom;
        s.lo      = $urandom;
        s.cp0     = $urandom;
        s.readsel = 3'($urandom_range(0, 7));
        s.a3sel   = 3'($urandom_range(0, 3));
        s.wdsel   = 3'($urandom_range(0, 7));
        s.grf_en  = ($urandom_range(0, 7) != 0);
        s.exc     = ($urandom_range(0, 9) == 0);
        s.ra1     = 5'($urandom_range(0, 31));
        s.ra2     = 5'($urandom_range(0, 31));
        return s;
    endfunction

    function automatic stim_t idle_read(input int a, input int b);
        stim_t s;
        s        = rand_stim();
        s.grf_en = 1'b0;
        s.ra1    = 5'(a);
        s.ra2    = 5'(b);
        return s;
    endfunction

    // Drive one W instruction, record what the spec says must come out, then advance one edge.
    task automatic apply(input stim_t s, input bit use_want, input logic [31:0] want,
                         input string tag);
        exp_t        e;
        logic [4:0]  dest;
        logic [31:0] val;
        bit          legal;
        reset         = s.reset;
        wif.w_instr   = s.instr;
        wif.w_pc8     = s.pc8;
        wif.w_alu     = s.alu;
        wif.w_dm_word = s.dm;
        wif.w_ext     = s.ext;
        wif.w_hi      = s.hi;
        wif.w_lo      = s.lo;
        wif.w_cp0     = s.cp0;
        wif.w_readsel = s.readsel;
        wif.w_a3sel   = s.a3sel;
        wif.w_wdsel   = s.wdsel;
        wif.w_grf_en  = s.grf_en;
        wif.w_exc     = s.exc;
        wif.ra1       = s.ra1;
        wif.ra2       = s.ra2;

        legal = (s.a3sel <= 3'd2) && (s.wdsel != 3'd7);
        dest  = (s.a3sel == 3'd0) ? s.instr[20:16] :
                (s.a3sel == 3'd1) ? s.instr[15:11] : 5'd31;
        case (s.wdsel)
            3'd0:    val = s.alu;
            3'd1:    val = load_ext(s.dm, s.alu, s.readsel);
            3'd2:    val = s.pc8;
            3'd3:    val = s.hi;
            3'd4:    val = s.lo;
            3'd5:    val = s.cp0;
            3'd6:    val = s.ext;
            default: val = 32'd0;
        endcase
        e.rst = s.reset;
        e.we  = s.grf_en && !s.exc && !s.reset && legal && (dest != 5'd0);
        e.a3  = e.we ? dest : 5'd0;
        e.wd  = use_want ? want : val;
        e.rd1 = (s.ra1 == 0) ? 32'd0 : (TB_BYPASS && e.we && s.ra1 == dest) ? val : mdl[s.ra1];
        e.rd2 = (s.ra2 == 0) ? 32'd0 : (TB_BYPASS && e.we && s.ra2 == dest) ? val : mdl[s.ra2];
        e.tag = tag;
        sb_q.push_back(e);

        if (s.reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if (e.we) begin
            mdl[dest] = val;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t load_stim(input logic [2:0] rsel, input logic [1:0] off);
        stim_t s;
        s         = rand_stim();
        s.grf_en  = 1'b1;
        s.exc     = 1'b0;
        s.a3sel   = 3'd0;
        s.instr[20:16] = 5'd9;
        s.wdsel   = 3'd1;
        s.readsel = rsel;
        s.alu     = {s.alu[31:2], off};
        s.dm      = 32'h80FF_7F01;
        return s;
    endfunction

    // Monitor: the outputs are combinational, so each driven cycle presents one response.
`ifdef W_TRACE_EN
    exp_t prev;
    bit   have_prev = 1'b0;
`endif
    always @(negedge clk) begin
`ifdef W_TRACE_EN
        if (have_prev) begin
            chk({prev.tag, ".trace_valid"}, 32'(trace_valid), 32'(prev.we));
            if (prev.we) begin
                chk({prev.tag, ".trace_reg"}, 32'(trace_reg), 32'(prev.a3));
                chk({prev.tag, ".trace_data"}, trace_data, prev.wd);
            end
        end
`endif
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, ".wb_we"}, 32'(wif.wb_we), 32'(e.we));
            chk({e.tag, ".wb_a3"}, 32'(wif.wb_a3), 32'(e.a3));
            if (e.we || e.rst) chk({e.tag, ".wb_wd"}, wif.wb_wd, e.rst ? 32'd0 : e.wd);
            chk({e.tag, ".rd1"}, wif.rd1, e.rd1);
            chk({e.tag, ".rd2"}, wif.rd2, e.rd2);
`ifdef W_TRACE_EN
            prev      = e;
            have_prev = 1'b1;
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            s        = rand_stim();
            s.reset  = 1'b1;
            s.grf_en = 1'b1;
            s.a3sel  = 3'd1;
            s.ra1    = 5'd0;
            s.ra2    = 5'd0;
            apply(s, 1'b0, 32'd0, "reset");
        end
        for (int i = 1; i < 32; i++) apply(idle_read(i, 32 - i), 1'b0, 32'd0, "clear");

        apply(load_stim(3'd2, 2'd3), 1'b1, 32'hFFFF_FF80, "lb");
        apply(load_stim(3'd1, 2'd3), 1'b1, 32'h0000_0080, "lbu");
        apply(load_stim(3'd4, 2'd2), 1'b1, 32'hFFFF_80FF, "lh");
        apply(load_stim(3'd3, 2'd2), 1'b1, 32'h0000_80FF, "lhu");

        s        = rand_stim();
        s.grf_en = 1'b1;
        s.exc    = 1'b0;
        s.a3sel  = 3'd2;
        s.wdsel  = 3'd2;
        s.pc8    = 32'h0000_3008;
        apply(s, 1'b1, 32'h0000_3008, "jal");
        apply(idle_read(31, 9), 1'b0, 32'd0, "jal_rd");

        s        = rand_stim();
        s.grf_en = 1'b1;
        s.exc    = 1'b0;
        s.a3sel  = 3'd0;
        s.wdsel  = 3'd0;
        s.instr[20:16] = 5'd0;
        s.ra1    = 5'd0;
        apply(s, 1'b0, 32'd0, "r0");

        s        = rand_stim();
        s.grf_en = 1'b1;
        s.exc    = 1'b0;
        s.a3sel  = 3'd1;
        s.wdsel  = 3'd0;
        s.instr[15:11] = 5'd5;
        s.alu    = 32'h1234_5678;
        apply(s, 1'b1, 32'h1234_5678, "w5");
        s.exc    = 1'b1;
        s.alu    = 32'hAAAA_5555;
        s.ra1    = 5'd5;
        apply(s, 1'b0, 32'd0, "exc");
        apply(idle_read(5, 5), 1'b0, 32'd0, "exc_rd");

        s        = rand_stim();
        s.grf_en = 1'b1;
        s.exc    = 1'b0;
        s.a3sel  = 3'd1;
        s.wdsel  = 3'd0;
        s.instr[15:11] = 5'd8;
        s.alu    = 32'hDEAD_BEEF;
        s.ra1    = 5'd8;
        s.ra2    = 5'd8;
        apply(s, 1'b1, 32'hDEAD_BEEF, "bypass");
        apply(idle_read(8, 8), 1'b0, 32'd0, "bypass_rd");

        for (int i = 0; i < 600; i++) begin
            s       = rand_stim();
            s.reset = ($urandom_range(0, 49) == 0);
            apply(s, 1'b0, 32'd0, "rand");
        end
        for (int i = 1; i < 32; i++) apply(idle_read(i, i), 1'b0, 32'd0, "final");

        @(posedge clk);
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
